// File: rtl/rat_pkg.sv
// rat_pkg: shared definitions for the rational arithmetic unit.
//   RAT_ADD/SUB/MUL/DIV : op encodings on the 2-bit op port
//   rat_state_e         : controller states of rat_alu
//   rat_iw()            : internal datapath width for a given operand width
package rat_pkg;

    localparam logic [1:0] RAT_ADD = 2'd0;
    localparam logic [1:0] RAT_SUB = 2'd1;
    localparam logic [1:0] RAT_MUL = 2'd2;
    localparam logic [1:0] RAT_DIV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_GCD  = 3'd2,
        ST_DIVN = 3'd3,
        ST_DIVD = 3'd4,
        ST_FMT  = 3'd5,
        ST_OUT  = 3'd6
    } rat_state_e;

    // Cross products of two WIDTH-bit values plus one add need 2*WIDTH+1 bits.
    function automatic int unsigned rat_iw(input int unsigned width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/rat_serdiv.sv
// rat_serdiv: W-bit unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_start      : load dividend/divisor (ignored while busy)
//   i_dividend   : unsigned dividend
//   i_divisor    : unsigned divisor, must be non-zero
//   o_busy       : a division is in progress
//   o_done_c     : combinational, high during the final step cycle; the
//                  quotient/remainder registers are valid from the next cycle
//   o_quo, o_rem : quotient and remainder of the last completed division
module rat_serdiv #(
    parameter int unsigned W = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done_c,
    output logic [W-1:0] o_quo,
    output logic [W-1:0] o_rem
);

    localparam int unsigned CW = $clog2(W + 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_dvs;
    logic [W:0]    w_shift;
    logic [W:0]    w_diff;

    // Dividend bits shift out of the quotient register into the remainder.
    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    // Load on start, then one restoring step per cycle for W cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(W);
            r_quo  <= i_dividend;
            r_rem  <= '0;
            r_dvs  <= i_divisor;
        end else if (r_busy) begin
            // Either branch leaves a value below the divisor, so W bits suffice.
            if (!w_diff[W]) begin
                r_rem <= w_diff[W-1:0];
                r_quo <= {r_quo[W-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[W-1:0];
                r_quo <= {r_quo[W-2:0], 1'b0};
            end
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done_c = r_busy && (r_cnt == CW'(1));
    assign o_quo    = r_quo;
    assign o_rem    = r_rem;

endmodule

// File: rtl/rat_alu.sv
// rat_alu: signed rational add/sub/mul/div with optional lowest-terms reduction.
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid / in_ready        : operand handshake (in_ready = idle, combinational)
//   op                         : 0 ADD, 1 SUB, 2 MUL, 3 DIV
//   l_num, l_den, r_num, r_den : signed operands
//   out_valid / out_ready      : result handshake, result held until taken
//   s_num, s_den               : signed result, s_den > 0 unless err
//   err                        : zero denominator in the result
//   ovf                        : reduced result exceeds WIDTH signed, low bits given
module rat_alu
    import rat_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned REDUCE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] l_num,
    input  logic [WIDTH-1:0] l_den,
    input  logic [WIDTH-1:0] r_num,
    input  logic [WIDTH-1:0] r_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_num,
    output logic [WIDTH-1:0] s_den,
    output logic             err,
    output logic             ovf
);

    localparam int unsigned IW = rat_iw(WIDTH);
    localparam int unsigned KW = $clog2(IW + 1);

    rat_state_e r_state;
    rat_state_e w_state_nxt;

    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_ln, r_ld, r_rn, r_rd;
    logic [IW-1:0]    r_pn, r_pd;
    logic             r_neg;
    logic [IW-1:0]    r_a, r_b;
    logic [KW-1:0]    r_k;
    logic [IW-1:0]    r_qn;
    logic [WIDTH-1:0] r_s_num, r_s_den;
    logic             r_err, r_ovf;

    logic signed [IW-1:0] w_ln, w_ld, w_rn, w_rd;
    logic signed [IW-1:0] w_pn_raw, w_pd_raw;
    logic signed [IW-1:0] w_pn_adj, w_pd_adj;
    logic                 w_gcd_eq;
    logic [IW-1:0]        w_pn_abs, w_g;
    logic [IW-1:0]        w_fn, w_fd;
    logic                 w_ovf;

    logic          w_div_start;
    logic [IW-1:0] w_div_dividend;
    logic          w_div_busy, w_div_done;
    logic [IW-1:0] w_div_quo, w_div_rem;

    assign w_ln = IW'($signed(r_ln));
    assign w_ld = IW'($signed(r_ld));
    assign w_rn = IW'($signed(r_rn));
    assign w_rd = IW'($signed(r_rd));

    // Cross products; a negative denominator flips the sign of both terms.
    always_comb begin
        w_pn_raw = '0;
        w_pd_raw = w_ld * w_rd;
        case (r_op)
            RAT_ADD: w_pn_raw = w_ln * w_rd + w_rn * w_ld;
            RAT_SUB: w_pn_raw = w_ln * w_rd - w_rn * w_ld;
            RAT_MUL: w_pn_raw = w_ln * w_rn;
            RAT_DIV: begin
                w_pn_raw = w_ln * w_rd;
                w_pd_raw = w_ld * w_rn;
            end
            default: w_pn_raw = '0;
        endcase
        w_pn_adj = w_pd_raw[IW-1] ? -w_pn_raw : w_pn_raw;
        w_pd_adj = w_pd_raw[IW-1] ? -w_pd_raw : w_pd_raw;
    end

    assign w_gcd_eq = (r_a == r_b);
    assign w_pn_abs = r_neg ? -r_pn : r_pn;
    assign w_g      = r_a << r_k;

    // Divider runs |pn|/g right out of GCD, then pd/g on the first DIVD cycle.
    assign w_div_start    = ((r_state == ST_GCD) && w_gcd_eq) ||
                            ((r_state == ST_DIVD) && !w_div_busy);
    assign w_div_dividend = (r_state == ST_GCD) ? w_pn_abs : r_pd;

    rat_serdiv #(
        .W (IW)
    ) u_serdiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (w_div_dividend),
        .i_divisor  (w_g),
        .o_busy     (w_div_busy),
        .o_done_c   (w_div_done),
        .o_quo      (w_div_quo),
        .o_rem      (w_div_rem)
    );

    // Final value selection and range check against WIDTH signed.
    always_comb begin
        w_fn = r_pn;
        w_fd = r_pd;
        if (REDUCE != 0) begin
            w_fn = r_neg ? -r_qn : r_qn;
            w_fd = w_div_quo;
        end
        w_ovf = (IW'($signed(w_fn[WIDTH-1:0])) != w_fn) ||
                (IW'($signed(w_fd[WIDTH-1:0])) != w_fd);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = ST_MULT;
            ST_MULT: begin
                if ((w_pd_raw == '0) || (w_pn_raw == '0)) begin
                    w_state_nxt = ST_OUT;
                end else if (REDUCE != 0) begin
                    w_state_nxt = ST_GCD;
                end else begin
                    w_state_nxt = ST_FMT;
                end
            end
            ST_GCD:  if (w_gcd_eq) w_state_nxt = ST_DIVN;
            ST_DIVN: if (w_div_done) w_state_nxt = ST_DIVD;
            ST_DIVD: if (w_div_done) w_state_nxt = ST_FMT;
            ST_FMT:  w_state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers, sequenced by the controller state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_ln    <= '0;
            r_ld    <= '0;
            r_rn    <= '0;
            r_rd    <= '0;
            r_pn    <= '0;
            r_pd    <= '0;
            r_neg   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_qn    <= '0;
            r_s_num <= '0;
            r_s_den <= '0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op <= op;
                        r_ln <= l_num;
                        r_ld <= l_den;
                        r_rn <= r_num;
                        r_rd <= r_den;
                    end
                end
                ST_MULT: begin
                    r_pn  <= w_pn_adj;
                    r_pd  <= w_pd_adj;
                    r_neg <= w_pn_adj[IW-1];
                    r_a   <= w_pn_adj[IW-1] ? -w_pn_adj : w_pn_adj;
                    r_b   <= w_pd_adj;
                    r_k   <= '0;
                    if (w_pd_raw == '0) begin
                        r_s_num <= '0;
                        r_s_den <= '0;
                        r_err   <= 1'b1;
                        r_ovf   <= 1'b0;
                    end else if (w_pn_raw == '0) begin
                        r_s_num <= '0;
                        r_s_den <= WIDTH'(1);
                        r_err   <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                // One Stein step: shared twos, then lone twos, then subtract.
                ST_GCD: begin
                    if (!w_gcd_eq) begin
                        if (!r_a[0] && !r_b[0]) begin
                            r_a <= r_a >> 1;
                            r_b <= r_b >> 1;
                            r_k <= r_k + KW'(1);
                        end else if (!r_a[0]) begin
                            r_a <= r_a >> 1;
                        end else if (!r_b[0]) begin
                            r_b <= r_b >> 1;
                        end else if (r_a > r_b) begin
                            r_a <= r_a - r_b;
                        end else begin
                            r_b <= r_b - r_a;
                        end
                    end
                end
                ST_DIVD: begin
                    if (!w_div_busy) begin
                        r_qn <= w_div_quo;
                    end
                end
                ST_FMT: begin
                    r_s_num <= w_fn[WIDTH-1:0];
                    r_s_den <= w_fd[WIDTH-1:0];
                    r_err   <= 1'b0;
                    r_ovf   <= w_ovf;
                end
                default: ;
            endcase
        end
    end

    // g divides both terms exactly, so each division leaves no remainder.
    always @(posedge clk) begin
        if (rst_n && (REDUCE != 0) &&
            (((r_state == ST_DIVD) && !w_div_busy) || (r_state == ST_FMT))) begin
            assert (w_div_rem == '0);
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_OUT);
    assign s_num     = r_s_num;
    assign s_den     = r_s_den;
    assign err       = r_err;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_rat_alu.sv
// tb_rat_alu: checks rat_alu at WIDTH=8 with REDUCE=1 (dut a) and REDUCE=0 (dut b).
module tb_rat_alu;
    import rat_pkg::*;

    localparam int unsigned W   = 8;
    localparam int          IWB = 2 * 8 + 1;
    localparam int          LAT_MAX = 5 * IWB + 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]   op;
    logic [W-1:0] l_num, l_den, r_num, r_den;

    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err, a_ovf;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err, b_ovf;
    logic [W-1:0] a_s_num, a_s_den, b_s_num, b_s_den;

    rat_alu #(.WIDTH(W), .REDUCE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .op(op), .l_num(l_num), .l_den(l_den), .r_num(r_num), .r_den(r_den),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .s_num(a_s_num), .s_den(a_s_den), .err(a_err), .ovf(a_ovf)
    );

    rat_alu #(.WIDTH(W), .REDUCE(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op(op), .l_num(l_num), .l_den(l_den), .r_num(r_num), .r_den(r_den),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .s_num(b_s_num), .s_den(b_s_den), .err(b_err), .ovf(b_ovf)
    );

    typedef struct {
        bit         sel;
        logic [1:0] op;
        logic [7:0] ln, ld, rn, rd;
        logic [7:0] en, ed;
        logic       ee, eo;
        int         lat;
        string      nm;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic vld(input bit s);
        return s ? b_out_valid : a_out_valid;
    endfunction

    // Reference: exact rational arithmetic, Euclid for the gcd.
    function automatic void model(input bit red, input logic [1:0] o,
                                  input logic signed [7:0] ln, ld, rn, rd,
                                  output logic [7:0] en, ed, output logic ee, eo,
                                  output bit sc);
        longint pn, pd, a, b, t, n, d;
        longint xln, xld, xrn, xrd;
        xln = ln; xld = ld; xrn = rn; xrd = rd;
        pd = xld * xrd;
        case (o)
            RAT_ADD: pn = xln * xrd + xrn * xld;
            RAT_SUB: pn = xln * xrd - xrn * xld;
            RAT_MUL: pn = xln * xrn;
            default: begin pn = xln * xrd; pd = xld * xrn; end
        endcase
        ee = 1'b0; eo = 1'b0; sc = 1'b1;
        if (pd == 0) begin
            en = 8'd0; ed = 8'd0; ee = 1'b1;
        end else if (pn == 0) begin
            en = 8'd0; ed = 8'd1;
        end else begin
            sc = 1'b0;
            if (pd < 0) begin pn = -pn; pd = -pd; end
            n = pn; d = pd;
            if (red) begin
                a = (pn < 0) ? -pn : pn;
                b = pd;
                while (b != 0) begin t = a % b; a = b; b = t; end
                n = pn / a; d = pd / a;
            end
            eo = (n < -128) || (n > 127) || (d > 127);
            en = n[7:0];
            ed = d[7:0];
        end
    endfunction

    task automatic send(input bit s, input logic [1:0] o,
                        input logic [7:0] ln, ld, rn, rd);
        @(negedge clk);
        op = o; l_num = ln; l_den = ld; r_num = rn; r_den = rd;
        if (s) b_in_valid = 1'b1; else a_in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    // Returns the cycle (accept edge = 0) in which out_valid is first seen.
    task automatic wait_out(input bit s, output int lat);
        lat = 1;
        while (!vld(s) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!vld(s)) begin
            total++;
            bad++;
            $display("FAIL timeout: no out_valid after %0d cycles", lat);
        end
    endtask

    task automatic check_out(input string nm, input bit s,
                             input logic [7:0] en, ed, input logic ee, eo);
        chk({nm, ".num"}, s ? b_s_num : a_s_num, en);
        chk({nm, ".den"}, s ? b_s_den : a_s_den, ed);
        chk({nm, ".err"}, s ? b_err : a_err, ee);
        chk({nm, ".ovf"}, s ? b_ovf : a_ovf, eo);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        send(v.sel, v.op, v.ln, v.ld, v.rn, v.rd);
        wait_out(v.sel, lat);
        check_out(v.nm, v.sel, v.en, v.ed, v.ee, v.eo);
        if (v.lat >= 0) chk({v.nm, ".lat"}, lat, v.lat);
        else            chk({v.nm, ".lat_bound"}, (lat <= LAT_MAX) ? 1 : 0, 1);
        @(posedge clk);
        #1;
    endtask

    vec_t vt[$];

    initial begin
        vec_t       v;
        int         lat;
        bit         seen;
        logic [7:0] en, ed;
        logic       ee, eo;
        bit         sc;

        // Latencies for dut a: 3 + stein cycles + 2*17 + 1.
        vt.push_back('{1'b0, RAT_ADD, 8'd1, 8'd2, 8'd1, 8'd3, 8'd5, 8'd6, 1'b0, 1'b0, 44, "add_5_6"});
        vt.push_back('{1'b0, RAT_SUB, 8'd1, 8'd2, 8'd3, 8'd4, 8'hFF, 8'd4, 1'b0, 1'b0, 42, "sub_m1_4"});
        vt.push_back('{1'b0, RAT_MUL, 8'd2, 8'd4, 8'd3, 8'd6, 8'd1, 8'd4, 1'b0, 1'b0, 42, "mul_1_4"});
        vt.push_back('{1'b0, RAT_MUL, 8'd1, 8'hFD, 8'd1, 8'd1, 8'hFF, 8'd3, 1'b0, 1'b0, 41, "mul_neg_den"});
        vt.push_back('{1'b0, RAT_DIV, 8'd1, 8'd2, 8'd0, 8'd5, 8'd0, 8'd0, 1'b1, 1'b0, 2, "div_by_zero"});
        vt.push_back('{1'b0, RAT_ADD, 8'd1, 8'd0, 8'd1, 8'd2, 8'd0, 8'd0, 1'b1, 1'b0, 2, "lden_zero"});
        vt.push_back('{1'b0, RAT_MUL, 8'd0, 8'd7, 8'd3, 8'd4, 8'd0, 8'd1, 1'b0, 1'b0, 2, "zero_num"});
        vt.push_back('{1'b0, RAT_MUL, 8'd100, 8'd1, 8'd100, 8'd1, 8'h10, 8'd1, 1'b0, 1'b1, -1, "mul_ovf"});
        vt.push_back('{1'b0, RAT_DIV, 8'd3, 8'd4, 8'hF7, 8'd8, 8'hFE, 8'd3, 1'b0, 1'b0, -1, "div_neg"});
        vt.push_back('{1'b0, RAT_ADD, 8'h80, 8'd1, 8'd0, 8'd1, 8'h80, 8'd1, 1'b0, 1'b0, -1, "min_fits"});
        vt.push_back('{1'b0, RAT_ADD, 8'd127, 8'd1, 8'd1, 8'd1, 8'h80, 8'd1, 1'b0, 1'b1, -1, "max_ovf"});
        vt.push_back('{1'b1, RAT_SUB, 8'd1, 8'd2, 8'd3, 8'd4, 8'hFE, 8'd8, 1'b0, 1'b0, 3, "nored_sub"});
        vt.push_back('{1'b1, RAT_MUL, 8'd2, 8'd4, 8'd3, 8'd6, 8'd6, 8'd24, 1'b0, 1'b0, 3, "nored_mul"});
        vt.push_back('{1'b1, RAT_DIV, 8'd1, 8'd2, 8'd0, 8'd5, 8'd0, 8'd0, 1'b1, 1'b0, 2, "nored_err"});

        rst_n = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        op = 2'd0; l_num = '0; l_den = '0; r_num = '0; r_den = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst.in_ready", a_in_ready, 1);
        chk("rst.out_valid", a_out_valid, 0);
        check_out("rst", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        chk("rst.b_in_ready", b_in_ready, 1);

        foreach (vt[i]) run_vec(vt[i]);

        // Consumer stalls for 10 cycles: result must hold and stay busy.
        a_out_ready = 1'b0;
        send(1'b0, RAT_ADD, 8'd1, 8'd2, 8'd1, 8'd3);
        wait_out(1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("stall.out_valid", a_out_valid, 1);
            chk("stall.in_ready", a_in_ready, 0);
            check_out("stall", 1'b0, 8'd5, 8'd6, 1'b0, 1'b0);
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall.released", a_out_valid, 0);
        chk("stall.idle", a_in_ready, 1);

        // Reset while reducing: transaction dropped, unit reusable.
        send(1'b0, RAT_ADD, 8'd1, 8'd2, 8'd1, 8'd3);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst.in_ready", a_in_ready, 1);
        chk("midrst.out_valid", a_out_valid, 0);
        check_out("midrst", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (a_out_valid) seen = 1'b1;
        end
        chk("midrst.no_output", seen, 0);
        run_vec('{1'b0, RAT_MUL, 8'd2, 8'd4, 8'd3, 8'd6, 8'd1, 8'd4, 1'b0, 1'b0, 42, "after_rst"});

        // Random operands against the exact reference.
        for (int i = 0; i < 80; i++) begin
            v.sel = (i >= 55);
            v.op  = 2'($urandom_range(0, 3));
            v.ln  = 8'($urandom);
            v.ld  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            v.rn  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            v.rd  = 8'($urandom);
            model(!v.sel, v.op, v.ln, v.ld, v.rn, v.rd, en, ed, ee, eo, sc);
            v.en = en; v.ed = ed; v.ee = ee; v.eo = eo;
            v.lat = sc ? 2 : (v.sel ? 3 : -1);
            v.nm = v.sel ? "rand_nored" : "rand_red";
            run_vec(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
